// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Captures bin on a rising edge of start and reports packed BCD plus significant-digit count.
module bin_to_bcd #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [3:0]            ndigits
);

    localparam int SW = 4 * DIGITS;
    localparam int TW = SW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Add 3 to every BCD digit that is 5 or more, so the following shift carries correctly.
    function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = s[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = s[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Position of the most significant nonzero digit plus one; a zero value still shows one digit.
    function automatic logic [3:0] sig_digits(input logic [SW-1:0] s);
        logic [3:0] n;
        n = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[4*i +: 4] != 4'd0) begin
                n = 4'(i + 1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    state_t          state_r;
    logic            start_q;
    logic [TW-1:0]   work_r;
    logic [CW-1:0]   cnt_r;

    logic            req_s;
    logic [TW-1:0]   corrected_s;
    logic [TW-1:0]   next_work_s;

    // Edge detect and one dabble step: scratch digits sit above the binary shift register.
    always_comb begin
        req_s       = start & ~start_q;
        corrected_s = {add3(work_r[TW-1:WIDTH]), work_r[WIDTH-1:0]};
        next_work_s = corrected_s << 1;
    end

    // Conversion FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            start_q <= 1'b0;
            work_r  <= '0;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
            ndigits <= 4'd1;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        work_r  <= {{SW{1'b0}}, bin};
                        cnt_r   <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    work_r <= next_work_s;
                    cnt_r  <= cnt_r - CW'(1);
                    // Final shift: publish the finished scratch value on this same edge.
                    if (cnt_r == CW'(1)) begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bcd     <= next_work_s[TW-1:WIDTH];
                        ndigits <= sig_digits(next_work_s[TW-1:WIDTH]);
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: randomized values against a decimal-arithmetic model,
// plus latency, edge-detect, ignore-while-busy and asynchronous reset-abort scenarios.
module tb_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] bin;
    logic        busy;
    logic        done;
    logic [39:0] bcd;
    logic [3:0]  ndigits;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic prev_done = 1'b0;

    bin_to_bcd #(.WIDTH(32), .DIGITS(10)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .ndigits(ndigits)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // done monitor: counts pulses and flags any pulse longer than one cycle
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            check("done_single_cycle", 64'(prev_done), 64'd0);
        end
        prev_done = done;
    end

    function automatic logic [39:0] ref_bcd(input logic [31:0] v);
        longint unsigned t;
        logic [39:0] r;
        t = 64'(v);
        r = '0;
        for (int i = 0; i < 10; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_nd(input logic [31:0] v);
        longint unsigned t;
        int n;
        t = 64'(v);
        n = 0;
        do begin
            n++;
            t = t / 10;
        end while (t != 0);
        return 4'(n);
    endfunction

    task automatic wait_done(input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - c0;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] v, input int lat);
        check({tag, "_latency"}, 64'(lat), 64'd32);
        check({tag, "_bcd"}, 64'(bcd), 64'(ref_bcd(v)));
        check({tag, "_ndigits"}, 64'(ndigits), 64'(ref_nd(v)));
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic run_conv(input logic [31:0] v, input string tag);
        int c0;
        int lat;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        c0    = cyc;
        start = 1'b0;
        bin   = $urandom;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(c0, lat);
        check_result(tag, v, lat);
    endtask

    initial begin
        int c0;
        int c1;
        int lat;
        int d0;
        logic [31:0] v;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_ndigits", 64'(ndigits), 64'd1);

        // start held high through reset release triggers one conversion
        bin   = 32'd12345;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        c0 = cyc;
        wait_done(c0, lat);
        check_result("held_through_reset", 32'd12345, lat);
        start = 1'b0;

        run_conv(32'd0, "zero");
        run_conv(32'd465, "v465");
        run_conv(32'd7, "v7");
        run_conv(32'hFFFF_FFFF, "max");
        run_conv(32'd1_000_000_000, "pow10");
        for (int i = 0; i < 20; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            run_conv(v, "random");
        end

        // held-high start converts once; a fresh edge converts again
        v = $urandom;
        @(negedge clk);
        d0    = done_cnt;
        bin   = v;
        start = 1'b1;
        repeat (100) @(negedge clk);
        check("held_one_done", 64'(done_cnt - d0), 64'd1);
        check("held_bcd", 64'(bcd), 64'(ref_bcd(v)));
        start = 1'b0;
        v = $urandom;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        c0 = cyc;
        wait_done(c0, lat);
        check_result("re_edge", v, lat);
        start = 1'b0;

        // requests during SHIFT are ignored; a request in the done cycle is accepted
        @(negedge clk);
        bin   = 32'd123456;
        start = 1'b1;
        @(negedge clk);
        c0    = cyc;
        d0    = done_cnt;
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        bin   = 32'd999;
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(c0, lat);
        check_result("busy_ignore", 32'd123456, lat);
        start = 1'b1;
        bin   = 32'd999;
        @(negedge clk);
        c1    = cyc;
        start = 1'b0;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_spacing", 64'(c1 - c0), 64'd33);
        wait_done(c1, lat);
        check_result("b2b", 32'd999, lat);
        @(negedge clk);
        check("busy_ignore_done_count", 64'(done_cnt - d0), 64'd2);

        // asynchronous reset after 10 shifts aborts without a done
        v = $urandom;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_bcd", 64'(bcd), 64'd0);
        check("abort_ndigits", 64'(ndigits), 64'd1);
        d0 = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        check("abort_bcd_held", 64'(bcd), 64'd0);
        run_conv($urandom, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
